// File: rtl/matmul_pkg.sv
// +--------------------------------------------------------------------+
// | matmul_pkg : shared types, width helpers and saturation bounds     |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCUM    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_OUTPUT   = 3'd3,
    ST_DONE     = 3'd4,
    ST_WAIT_CLR = 3'd5
  } state_t;

  // Counter width for values 0..count-1, never narrower than one bit.
  function automatic int bits_for(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_compute_mac.sv
// +--------------------------------------------------------------------+
// | mac_unit : registered signed multiply-accumulate, clear and enable |
// | ACC_SATURATE_EN selects sticky saturation instead of wrap-around.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module mac_unit
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic signed [INW-1:0]  i_a,
  input  logic signed [INW-1:0]  i_b,
  output logic signed [OUTW-1:0] o_acc
);

  logic signed [2*INW-1:0] w_prod;
  logic signed [OUTW-1:0]  w_prod_ext;
  logic signed [OUTW-1:0]  w_acc_next;
  logic signed [OUTW-1:0]  r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = OUTW'(w_prod);

`ifdef ACC_SATURATE_EN
  localparam logic signed [OUTW-1:0] c_SAT_HI = OUTW'(sat_hi(OUTW));
  localparam logic signed [OUTW-1:0] c_SAT_LO = OUTW'(sat_lo(OUTW));

  logic [OUTW:0] w_wide;
  logic          w_ovf;
  logic          r_sat;

  assign w_wide = {r_acc[OUTW-1], r_acc} + {w_prod_ext[OUTW-1], w_prod_ext};
  assign w_ovf  = w_wide[OUTW] ^ w_wide[OUTW-1];

  always_comb begin
    w_acc_next = r_acc;
    if (i_clr) begin
      w_acc_next = '0;
    end else if (i_en && !r_sat) begin
      w_acc_next = w_ovf ? (w_wide[OUTW] ? c_SAT_LO : c_SAT_HI) : w_wide[OUTW-1:0];
    end
  end

  // Once clipped, the element keeps its bound until the next clear.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sat <= 1'b0;
    end else if (i_en && !r_sat && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_acc_next = i_clr ? '0 : (i_en ? r_acc + w_prod_ext : r_acc);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/matmul_compute.sv
// +--------------------------------------------------------------------+
// | matmul_compute : C = A*B over synchronous A/B read ports, streamed |
// | row-major on AXI-Stream. Optional macro: ACC_SATURATE_EN.          |
// | Revision       : 1.0 - initial release                             |
// +--------------------------------------------------------------------+
`default_nettype none

module matmul_compute
  import matmul_pkg::*;
#(
  parameter  int INW         = 12,
  parameter  int OUTW        = 32,
  parameter  int M           = 7,
  parameter  int N           = 9,
  parameter  int MAXK        = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic signed [INW-1:0]  A_data,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  input  logic signed [INW-1:0]  B_data,
  output logic                   compute_finished,
  output logic [OUTW-1:0]        AXIS_OUT_TDATA,
  output logic                   AXIS_OUT_TVALID,
  input  logic                   AXIS_OUT_TREADY
);

  localparam int c_M_BITS = bits_for(M);
  localparam int c_N_BITS = bits_for(N);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [K_BITS-1:0]        r_kl;
  logic [K_BITS-1:0]        r_k;
  logic [c_M_BITS-1:0]      r_m;
  logic [c_N_BITS-1:0]      r_n;
  logic [A_ADDR_BITS-1:0]   r_a_base;
  logic [A_ADDR_BITS-1:0]   r_a_addr;
  logic [B_ADDR_BITS-1:0]   r_b_addr;
  logic                     r_vld;
  logic                     w_clr;
  logic                     w_hs;
  logic                     w_last_k;
  logic                     w_last_n;
  logic                     w_last_m;
  logic signed [OUTW-1:0]   w_acc;

  assign w_hs     = (r_state == ST_OUTPUT) && AXIS_OUT_TREADY;
  assign w_last_k = (r_k == r_kl - K_BITS'(1));
  assign w_last_n = (r_n == c_N_BITS'(N - 1));
  assign w_last_m = (r_m == c_M_BITS'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (matrices_loaded) begin
          w_clr        = 1'b1;
          w_state_next = (K == '0) ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM:  if (w_last_k) w_state_next = ST_DRAIN;
      ST_DRAIN:  w_state_next = ST_OUTPUT;
      ST_OUTPUT: begin
        if (AXIS_OUT_TREADY) begin
          if (w_last_m && w_last_n) begin
            w_state_next = ST_DONE;
          end else begin
            w_clr        = 1'b1;
            w_state_next = (r_kl == '0) ? ST_OUTPUT : ST_ACCUM;
          end
        end
      end
      ST_DONE:     w_state_next = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!matrices_loaded) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Running address bases: A row base steps by K, B column address by N.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kl     <= '0;
      r_k      <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_a_base <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_vld <= (r_state == ST_ACCUM);
      if (r_state == ST_IDLE && matrices_loaded) begin
        r_kl     <= K;
        r_k      <= '0;
        r_m      <= '0;
        r_n      <= '0;
        r_a_base <= '0;
        r_a_addr <= '0;
        r_b_addr <= '0;
      end else if (r_state == ST_ACCUM) begin
        r_k      <= r_k + K_BITS'(1);
        r_a_addr <= r_a_addr + A_ADDR_BITS'(1);
        r_b_addr <= r_b_addr + B_ADDR_BITS'(N);
      end else if (w_hs) begin
        r_k <= '0;
        if (w_last_n) begin
          r_n      <= '0;
          r_m      <= r_m + c_M_BITS'(1);
          r_a_base <= r_a_base + A_ADDR_BITS'(r_kl);
          r_a_addr <= r_a_base + A_ADDR_BITS'(r_kl);
          r_b_addr <= '0;
        end else begin
          r_n      <= r_n + c_N_BITS'(1);
          r_a_addr <= r_a_base;
          r_b_addr <= B_ADDR_BITS'(r_n) + B_ADDR_BITS'(1);
        end
      end
    end
  end

  mac_unit #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (r_vld),
    .i_a   (A_data),
    .i_b   (B_data),
    .o_acc (w_acc)
  );

  // The accumulator is idle throughout OUTPUT, so it doubles as the output register.
  assign A_read_addr      = (r_state == ST_ACCUM) ? r_a_addr : '0;
  assign B_read_addr      = (r_state == ST_ACCUM) ? r_b_addr : '0;
  assign AXIS_OUT_TVALID  = (r_state == ST_OUTPUT);
  assign AXIS_OUT_TDATA   = (r_state == ST_OUTPUT) ? w_acc : '0;
  assign compute_finished = (r_state == ST_DONE);

endmodule

`default_nettype wire
